// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs -- oversampling UART receiver with a small receive FIFO.
//
// The serial line is resynchronised, a start edge restarts a bit-period
// counter, every bit is sampled at its middle and complete frames are
// pushed into a FIFO that the consumer drains with a valid/ready handshake.
//
// Ports
//   clk         system clock, everything on the rising edge
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   dato        data word at the FIFO head (0 while the FIFO is empty)
//   valido      FIFO non-empty, dato is valid
//   listo       consumer takes dato this cycle
//   errTrama    one-cycle pulse: stop bit sampled low
//   errParidad  one-cycle pulse: parity mismatch (frame had good stop bits)
//   desborde    one-cycle pulse: good frame dropped because the FIFO was full
//   ocupado     receiver is anywhere but idle
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a high-to-low edge on the synchronised line
// START | counting to the middle of the start bit to confirm it is low
// DATA  | sampling DATA_BITS data bits, LSB first, once per bit period
// PARITY| sampling the parity bit (only when PARITY != 0)
// STOP  | sampling STOP_BITS stop bits; decides push / flag at the end
// WAITH | line stuck low after a framing error; wait for it to go high

`timescale 1ns/1ps

module uart_rx_ovs #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dato,
    output logic                 valido,
    input  logic                 listo,
    output logic                 errTrama,
    output logic                 errParidad,
    output logic                 desborde,
    output logic                 ocupado
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAITHIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser plus one extra flop for edge detection
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par_err, par_err_n;
    logic                   fr_err, fr_err_n;
    logic                   fr_now;
    logic                   push_req;
    logic                   set_err_trama;
    logic                   set_err_par;
    logic                   tick_bit;

    assign tick_bit = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            fr_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par_err <= par_err_n;
            fr_err  <= fr_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt + 1'b1;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        par_err_n     = par_err;
        fr_err_n      = fr_err;
        fr_now        = 1'b0;
        push_req      = 1'b0;
        set_err_trama = 1'b0;
        set_err_par   = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    state_n = S_START;
                end
            end

            S_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n = '0;
                    if (!rx_sync) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                        par_err_n = 1'b0;
                        fr_err_n  = 1'b0;
                    end else begin
                        // too short to be a start bit
                        state_n = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (tick_bit) begin
                    cnt_n   = '0;
                    shreg_n = {rx_sync, shreg[DATA_BITS-1:1]};
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end

            S_PARITY: begin
                if (tick_bit) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = S_STOP;
                    if (PARITY == 1) begin
                        par_err_n = ~(^shreg ^ rx_sync);
                    end else begin
                        par_err_n = ^shreg ^ rx_sync;
                    end
                end
            end

            S_STOP: begin
                if (tick_bit) begin
                    cnt_n    = '0;
                    fr_now   = fr_err | ~rx_sync;
                    fr_err_n = fr_now;
                    if (bit_idx == STOP_LAST) begin
                        // framing error wins over a parity error in the same frame
                        if (fr_now) begin
                            set_err_trama = 1'b1;
                            state_n       = S_WAITHIGH;
                        end else if (par_err) begin
                            set_err_par = 1'b1;
                            state_n     = S_IDLE;
                        end else begin
                            push_req = 1'b1;
                            state_n  = S_IDLE;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end

            S_WAITHIGH: begin
                cnt_n = '0;
                if (rx_sync) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign ocupado = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 overflow;

    assign full     = (count == FULL_CNT);
    assign valido   = (count != '0);
    assign pop      = valido && listo;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;
    assign dato     = valido ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            errTrama   <= 1'b0;
            errParidad <= 1'b0;
            desborde   <= 1'b0;
        end else begin
            errTrama   <= set_err_trama;
            errParidad <= set_err_par;
            desborde   <= overflow;
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
`timescale 1ns/1ps

module tb_uart_rx_ovs;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rx = 2'b11;
    logic [1:0] listo = 2'b00;

    logic [7:0] dato_w [2];
    logic [1:0] valido_w;
    logic [1:0] errt_w;
    logic [1:0] errp_w;
    logic [1:0] desb_w;
    logic [1:0] ocup_w;

    always #5 clk = ~clk;

    // index 0: no parity, index 1: even parity
    uart_rx_ovs #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rx(rx[0]), .dato(dato_w[0]), .valido(valido_w[0]),
        .listo(listo[0]), .errTrama(errt_w[0]), .errParidad(errp_w[0]),
        .desborde(desb_w[0]), .ocupado(ocup_w[0]));

    uart_rx_ovs #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .rx(rx[1]), .dato(dato_w[1]), .valido(valido_w[1]),
        .listo(listo[1]), .errTrama(errt_w[1]), .errParidad(errp_w[1]),
        .desborde(desb_w[1]), .ocupado(ocup_w[1]));

    // pulse counters and valid-rise timestamp, sampled mid-cycle
    int cyc = 0;
    int et_cnt [2] = '{0, 0};
    int ep_cnt [2] = '{0, 0};
    int ov_cnt [2] = '{0, 0};
    int rise0 = -1;
    logic v0_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        v0_prev <= valido_w[0];
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                et_cnt[s] <= et_cnt[s] + 32'(errt_w[s]);
                ep_cnt[s] <= ep_cnt[s] + 32'(errp_w[s]);
                ov_cnt[s] <= ov_cnt[s] + 32'(desb_w[s]);
            end
            if (valido_w[0] && !v0_prev) rise0 <= cyc;
        end
    end

    int nchk = 0;
    int nerr = 0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_push;
        int         exp_et;
        int         exp_ep;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int s, input logic [7:0] d, input bit bad_par, input bit bad_stop);
        rx[s] = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx[s] = d[i];
            tick(CPB);
        end
        if (s == 1) begin
            rx[s] = (^d) ^ bad_par;
            tick(CPB);
        end
        rx[s] = !bad_stop;
        tick(CPB);
        rx[s] = 1'b1;
        tick(2 * CPB);
    endtask

    // drains with random listo, checks dato stability while stalled
    task automatic drain(input int s);
        int idle;
        bit pv;
        bit pl;
        logic [7:0] pd;
        idle = 0;
        pv = 1'b0;
        pl = 1'b0;
        pd = '0;
        got_q.delete();
        for (int c = 0; c < 400 && idle < 4; c++) begin
            listo[s] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pv && !pl && valido_w[s]) chk("dato_hold", int'(dato_w[s]), int'(pd));
            if (valido_w[s] && listo[s]) got_q.push_back(dato_w[s]);
            idle = valido_w[s] ? 0 : idle + 1;
            pv = valido_w[s];
            pl = listo[s];
            pd = dato_w[s];
            @(posedge clk);
            #1;
        end
        listo[s] = 1'b0;
        if (idle < 4) chk("drain_timeout", 0, 1);
    endtask

    task automatic compare_q(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({nm, "_word"}, int'(got_q[i]), int'(exp_q[i]));
    endtask

    initial begin
        int et0, ep0, ov0, st, lat, n;
        logic [7:0] d;
        bit bs, bp;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[2] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{1, 8'h03, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[5] = '{1, 8'h03, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[6] = '{1, 8'hA5, 1'b1, 1'b1, 1'b0, 1, 0};
        tbl[7] = '{1, 8'h80, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[8] = '{1, 8'h7E, 1'b1, 1'b0, 1'b0, 0, 1};

        // reset state
        tick(5);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_valido", int'(valido_w[s]), 0);
            chk("rst_dato", int'(dato_w[s]), 0);
            chk("rst_ocupado", int'(ocup_w[s]), 0);
            chk("rst_pulses", int'({errt_w[s], errp_w[s], desb_w[s]}), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4);

        // first frame: latency from start edge to valido
        st = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        lat = rise0 - st;
        chk("latency_window", int'(lat >= 148 && lat <= 164), 1);
        chk("lat_et", et_cnt[0], 0);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        drain(0);
        compare_q("first_frame");

        // table of single frames
        for (int i = 0; i < 9; i++) begin
            et0 = et_cnt[tbl[i].sel];
            ep0 = ep_cnt[tbl[i].sel];
            send_frame(tbl[i].sel, tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop);
            chk("tbl_errTrama", et_cnt[tbl[i].sel] - et0, tbl[i].exp_et);
            chk("tbl_errParidad", ep_cnt[tbl[i].sel] - ep0, tbl[i].exp_ep);
            exp_q.delete();
            if (tbl[i].exp_push) exp_q.push_back(tbl[i].data);
            drain(tbl[i].sel);
            compare_q("tbl");
        end

        // short glitch on the line
        et0 = et_cnt[0]; ep0 = ep_cnt[0]; ov0 = ov_cnt[0];
        rx[0] = 1'b0;
        tick(4);
        rx[0] = 1'b1;
        @(negedge clk);
        chk("glitch_busy", int'(ocup_w[0]), 1);
        tick(10);
        @(negedge clk);
        chk("glitch_idle", int'(ocup_w[0]), 0);
        tick(CPB * 2);
        chk("glitch_flags", et_cnt[0] - et0 + ep_cnt[0] - ep0 + ov_cnt[0] - ov0, 0);
        chk("glitch_nopush", int'(valido_w[0]), 0);

        // framing error followed by a held-low break
        et0 = et_cnt[0];
        rx[0] = 1'b0;
        tick(CPB);
        d = 8'h55;
        for (int i = 0; i < 8; i++) begin
            rx[0] = d[i];
            tick(CPB);
        end
        rx[0] = 1'b0;
        tick(CPB + 40);
        @(negedge clk);
        chk("break_errTrama", et_cnt[0] - et0, 1);
        chk("break_waithigh", int'(ocup_w[0]), 1);
        @(posedge clk);
        #1;
        rx[0] = 1'b1;
        tick(10);
        @(negedge clk);
        chk("break_released", int'(ocup_w[0]), 0);
        chk("break_nopush", int'(valido_w[0]), 0);
        chk("break_once", et_cnt[0] - et0, 1);
        tick(CPB);

        // overflow: five frames with no consumer
        ov0 = ov_cnt[0];
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0);
            if (i <= 4) exp_q.push_back(8'(i));
        end
        chk("ovf_desborde", ov_cnt[0] - ov0, 1);
        drain(0);
        compare_q("ovf");

        // reset in the middle of data bit 3 of 0xFF
        et0 = et_cnt[0]; ep0 = ep_cnt[0];
        rx[0] = 1'b0;
        tick(CPB);
        rx[0] = 1'b1;
        tick(3 * CPB + CPB / 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(CPB * 8);
        send_frame(0, 8'h12, 1'b0, 1'b0);
        chk("rstmid_flags", et_cnt[0] - et0 + ep_cnt[0] - ep0, 0);
        exp_q.delete();
        exp_q.push_back(8'h12);
        drain(0);
        compare_q("rstmid");

        // random bursts against a frame-level reference model
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 6; b++) begin
                int e_et, e_ep, e_ov;
                e_et = 0; e_ep = 0; e_ov = 0;
                et0 = et_cnt[s]; ep0 = ep_cnt[s]; ov0 = ov_cnt[s];
                exp_q.delete();
                n = $urandom_range(1, 6);
                for (int f = 0; f < n; f++) begin
                    d  = 8'($urandom);
                    bs = ($urandom_range(0, 7) == 0);
                    bp = (s == 1) && ($urandom_range(0, 3) == 0);
                    send_frame(s, d, bp, bs);
                    if (bs) e_et++;
                    else if (bp) e_ep++;
                    else if (exp_q.size() < 4) exp_q.push_back(d);
                    else e_ov++;
                end
                chk("rnd_errTrama", et_cnt[s] - et0, e_et);
                chk("rnd_errParidad", ep_cnt[s] - ep0, e_ep);
                chk("rnd_desborde", ov_cnt[s] - ov0, e_ov);
                drain(s);
                compare_q("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per bit period (50 MHz / 115200), legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, power of two, legal range 2..64.
REQ-006 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have port rx, input, 1, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port dato, output, DATA_BITS, meaning data word at the FIFO head.
REQ-010 SHALL have port valido, output, 1, meaning FIFO non-empty and dato is valid.
REQ-011 SHALL have port listo, input, 1, meaning consumer accepts dato this cycle.
REQ-012 SHALL have port errTrama, output, 1, meaning one-cycle pulse on framing error.
REQ-013 SHALL have port errParidad, output, 1, meaning one-cycle pulse on parity error.
REQ-014 SHALL have port desborde, output, 1, meaning one-cycle pulse on frame lost to a full FIFO.
REQ-015 SHALL have port ocupado, output, 1, meaning high in every state except IDLE.

Function
REQ-016 SHALL pass rx through a two-flop synchroniser; all sampling uses the synchronised value (2-cycle input latency).
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAITHIGH.
REQ-018 IDLE -> START on synchronised rx high-to-low; a bit-period counter restarts at 0.
REQ-019 START SHALL sample at count CLKS_PER_BIT/2 (integer division); low -> DATA with counter reset; high -> IDLE (glitch rejected, no flags).
REQ-020 DATA SHALL sample every CLKS_PER_BIT cycles from the start midpoint, LSB first, DATA_BITS samples; then PARITY if PARITY!=0, else STOP.
REQ-021 PARITY SHALL sample one bit; error if data XOR parity bit is 0 for odd parity or 1 for even parity.
REQ-022 STOP SHALL sample STOP_BITS bits at mid-bit; any low sample is a framing error.
REQ-023 On frame end: framing error -> errTrama pulse, no push, WAITHIGH; else parity error -> errParidad pulse, no push, IDLE; else push to FIFO, IDLE.
REQ-024 When framing and parity errors coincide, only errTrama SHALL pulse.
REQ-025 WAITHIGH SHALL hold until synchronised rx is high for one cycle, then IDLE (break handling).
REQ-026 Push with FIFO full SHALL drop the new frame, pulse desborde, and leave FIFO contents unchanged.
REQ-027 Pop SHALL occur when valido and listo are both high; listo with valido low is ignored.
REQ-028 Simultaneous push and pop on a full FIFO SHALL succeed for both, with no desborde.
REQ-029 A pushed word SHALL be visible on dato/valido one cycle after the push when the FIFO was empty.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
REQ-031 dato SHALL hold its value while valido is high and listo is low.

Reset
REQ-032 rst SHALL force IDLE, clear counters and FIFO pointers, and set valido=0, errTrama=0, errParidad=0, desborde=0, ocupado=0, dato=0, synchroniser flops=1.
REQ-033 rst asserted mid-frame SHALL abandon the frame without a push or flag; reception resumes on the next falling edge after release.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-034 PARITY=0, frame 0xA5 -> dato=0xA5, valido=1 about 10 bit periods after the start edge; no error pulses.
REQ-035 PARITY=2, byte 0x03 with parity bit 1 -> errParidad pulses once, valido stays 0; next frame 0x03 with parity bit 0 -> dato=0x03.
REQ-036 rx low for 4 cycles, then high -> returns to IDLE, ocupado low within 10 cycles, no flags, no push.
REQ-037 Frame 0x55 with stop bit 0, then rx held low 40 cycles -> errTrama pulses once, stays in WAITHIGH until rx rises, no push.
REQ-038 Five frames 0x01..0x05 with listo=0 -> desborde pulses once on the fifth; popping yields 0x01..0x04 in order, then valido=0.
REQ-039 rst pulsed during data bit 3 of 0xFF, then frame 0x12 -> only 0x12 is received.
